// File: rtl/pe_ws_cs.sv
// Weight-stationary systolic PE: double-buffered weight times streaming activation,
// folded into a carry-save partial-sum pair with one register stage.
module pe_ws_cs #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sign_mode,
    input  logic [DW-1:0]   w_in,
    input  logic            w_load,
    input  logic            w_swap,
    output logic [DW-1:0]   w_out,
    output logic            w_load_out,
    input  logic [DW-1:0]   a_in,
    input  logic            a_valid,
    output logic [DW-1:0]   a_out,
    output logic            a_valid_out,
    input  logic [ACCW-1:0] psum_in0,
    input  logic [ACCW-1:0] psum_in1,
    output logic [ACCW-1:0] psum_out0,
    output logic [ACCW-1:0] psum_out1
);

    logic [DW-1:0]   w_act;
    logic [DW-1:0]   w_shadow;
    logic [ACCW-1:0] w_ext;
    logic [ACCW-1:0] a_ext;
    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] maj;
    logic [ACCW-1:0] csa_sum;
    logic [ACCW-1:0] csa_carry;

    // The 2*DW product always fits in ACCW bits, so multiplying the extended
    // operands modulo 2^ACCW equals the sign/zero-extended 2*DW product.
    always_comb begin
        w_ext     = {{(ACCW-DW){sign_mode & w_act[DW-1]}}, w_act};
        a_ext     = {{(ACCW-DW){sign_mode & a_in[DW-1]}}, a_in};
        prod      = w_ext * a_ext;
        maj       = (prod & psum_in0) | (prod & psum_in1) | (psum_in0 & psum_in1);
        csa_sum   = prod ^ psum_in0 ^ psum_in1;
        csa_carry = {maj[ACCW-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_act       <= '0;
            w_shadow    <= '0;
            w_out       <= '0;
            w_load_out  <= 1'b0;
            a_out       <= '0;
            a_valid_out <= 1'b0;
            psum_out0   <= '0;
            psum_out1   <= '0;
        end else if (en) begin
            w_out       <= w_in;
            w_load_out  <= w_load;
            a_out       <= a_in;
            a_valid_out <= a_valid;
            if (w_load)
                w_shadow <= w_in;
            // Swap reads the old shadow, so load+swap together moves the previous value.
            if (w_swap)
                w_act <= w_shadow;
            if (a_valid) begin
                psum_out0 <= csa_sum;
                psum_out1 <= csa_carry;
            end
        end
    end

endmodule
